// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register with valid/ready handshake,
//               synchronous flush and a saturating stall-cycle counter.
//               Optional feature macro: PIPE_STAGE_REG_SKID_EN
//                 defined   -> EMPTY/FULL/SKID machine, registered in_ready
//                 undefined -> EMPTY/FULL machine,
//                              in_ready = !out_valid | out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      stall_count
);

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [15:0]      stall_q;
    logic [15:0]      stall_d;

    logic             w_in_xfer;
    logic             w_out_xfer;

`ifdef PIPE_STAGE_REG_SKID_EN
    // Second entry slot catches the one input accepted while downstream stalls.
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic             in_ready_d;

    assign in_ready = in_ready_q;
`else
    // Single slot: space exists when empty or when the held entry leaves now.
    assign in_ready = !out_valid_q | out_ready;
`endif

    assign w_in_xfer   = in_valid & in_ready;
    assign w_out_xfer  = out_valid_q & out_ready;

    assign out_valid   = out_valid_q;
    assign out_data    = main_q;
    assign stall_count = stall_q;

    // Next-state and datapath selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            // Data registers keep their contents, only occupancy is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        main_d = in_data;
                    end else if (w_out_xfer) begin
                        state_d = ST_EMPTY;
                    end
`ifdef PIPE_STAGE_REG_SKID_EN
                    else if (w_in_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end
`endif
                end
`ifdef PIPE_STAGE_REG_SKID_EN
                ST_SKID: begin
                    if (w_out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are precomputed from the next state so they leave flops.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
        in_ready_d  = (state_d != ST_SKID);
`endif
    end

    // Stall counter: counts cycles the held entry is refused, saturating.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State, main data, valid and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    // Skid data and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A queue-based model
//               of the stage (capacity 2 with PIPE_STAGE_REG_SKID_EN, else 1)
//               is compared against the DUT every cycle, plus directed
//               literal checks for the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] stall_count;

    logic        in_valid8  = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_data8   = 8'h00;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  out_data8;
    logic [15:0] stall_count8;
    logic        flush8     = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // model state
    logic [31:0] mq[$];
    int unsigned m_stall = 0;
    logic [31:0] m_last  = 32'h0;

    // stimulus bookkeeping
    bit          acc_in;
    logic [31:0] got[$];
    logic [31:0] prod[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush8),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .in_data     (in_data8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .out_data    (out_data8),
        .stall_count (stall_count8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready(input bit ordy);
`ifdef PIPE_STAGE_REG_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    // Reference model: an in-order queue of live entries.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_stall = 0;
                m_last  = 32'h0;
            end else begin
                bit mv;
                bit ix;
                bit ox;
                mv = (mq.size() > 0);
                ix = in_valid && m_in_ready(out_ready);
                ox = mv && out_ready;
                if (mv && !out_ready && m_stall < 65535) m_stall++;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (ox) void'(mq.pop_front());
                    if (ix) mq.push_back(in_data);
                end
                if (mq.size() > 0) m_last = mq[0];
            end
        end
    end

    // Compare process: DUT against model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("out_valid", {31'h0, out_valid}, {31'h0, (mq.size() > 0)});
            chk("in_ready", {31'h0, in_ready}, {31'h0, m_in_ready(out_ready)});
            chk("out_data", out_data, m_last);
            chk("stall_count", {16'h0, stall_count}, m_stall);
        end
    end

    task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        acc_in = in_valid && in_ready;
        if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_stall", {16'h0, stall_count}, 32'h0);
        chk("w8_rst_data", {24'h0, out_data8}, 32'h5A);
        chk("w8_rst_valid", {31'h0, out_valid8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8-bit instance passes 0xFF unmodified
        @(negedge clk);
        in_valid8 = 1'b1;
        in_data8  = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        in_data8  = 8'h00;
        #2;
        chk("w8_valid", {31'h0, out_valid8}, 32'h1);
        chk("w8_data", {24'h0, out_data8}, 32'hFF);

        // back-to-back 0x11..0x88
        got.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i + 1) * 32'h11, 1'b1, 1'b0);
            if (i > 0) begin
                chk("t1_valid", {31'h0, out_valid}, 32'h1);
                chk("t1_data", out_data, i * 32'h11);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_count", got.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk("t1_order", got[i], (i + 1) * 32'h11);
        end
        chk("t1_stall", {16'h0, stall_count}, 32'h0);

        // backpressure while FULL holding 0xA5
        got.delete();
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        prod.delete();
        prod.push_back(32'hB6);
        prod.push_back(32'hC7);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, prod[0], 1'b0, 1'b0);
`ifdef PIPE_STAGE_REG_SKID_EN
            chk("t2_in_ready", {31'h0, in_ready}, (k == 0) ? 32'h1 : 32'h0);
`else
            chk("t2_in_ready", {31'h0, in_ready}, 32'h0);
`endif
            if (acc_in) void'(prod.pop_front());
        end
        for (int r = 0; r < 5; r++) begin
            if (prod.size() > 0) step(1'b1, prod[0], 1'b1, 1'b0);
            else step(1'b0, 32'h0, 1'b1, 1'b0);
            if (acc_in && prod.size() > 0) void'(prod.pop_front());
        end
        chk("t2_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("t2_first", got[0], 32'hA5);
            chk("t2_second", got[1], 32'hB6);
            chk("t2_third", got[2], 32'hC7);
        end
        chk("t2_stall", {16'h0, stall_count}, 32'd3);

        // flush while stalled (SKID in skid build)
        got.delete();
        step(1'b1, 32'h31, 1'b0, 1'b0);
        step(1'b1, 32'h42, 1'b0, 1'b0);
        step(1'b1, 32'hDD, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_valid", {31'h0, out_valid}, 32'h0);
        chk("t3_in_ready", {31'h0, in_ready}, 32'h1);
        chk("t3_stall", {16'h0, stall_count}, 32'd5);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_nothing_out", got.size(), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end

        // asynchronous reset mid-stream
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h77, 1'b1, 1'b0);
        step(1'b1, 32'h78, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_data", out_data, 32'h0);
        chk("t5_in_ready", {31'h0, in_ready}, 32'h1);
        chk("t5_stall", {16'h0, stall_count}, 32'h0);
        step(1'b1, 32'h55, 1'b1, 1'b0);
        step(1'b1, 32'h56, 1'b1, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        got.delete();
        step(1'b1, 32'h99, 1'b1, 1'b0);
        step(1'b1, 32'hAA, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("t5_first", got[0], 32'h99);
            chk("t5_second", got[1], 32'hAA);
        end

        // stall counter saturation
        step(1'b1, 32'h12, 1'b0, 1'b0);
        for (int n = 0; n < 70000; n++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_saturated", {16'h0, stall_count}, 32'hFFFF);
        chk("t4_valid", {31'h0, out_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_reset_stall", {16'h0, stall_count}, 32'h0);
        chk("w8_stall", {16'h0, stall_count8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
